// File: rtl/glitch_pkg.sv
// -----------------------------------------------------------------------------
// glitch_pkg
// Shared definitions for the glitch scheduler:
//   glitch_state_t : FSM state encoding (IDLE, ARMED, DELAY, PULSE, GAP)
//   LFSR_SEED      : reset value of the optional jitter LFSR
//   JITTER_W       : width of the random offset added to DELAY/GAP lengths
//   LFSR_TAPS      : Galois feedback mask for the 16-bit maximal-length LFSR
// -----------------------------------------------------------------------------
package glitch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    DELAY = 3'd2,
    PULSE = 3'd3,
    GAP   = 3'd4
  } glitch_state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int          JITTER_W  = 3;

endpackage

// File: rtl/glitch_lfsr.sv
// -----------------------------------------------------------------------------
// glitch_lfsr
// 16-bit Galois LFSR, reseeded to LFSR_SEED on reset and advanced every clock.
// Its low JITTER_W bits supply the random DELAY/GAP offset of the scheduler.
// The module only exists when GLITCH_SCHED_JITTER_EN is defined, so a default
// build carries no LFSR logic at all.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high
//   jitter : current random offset, 0..2^JITTER_W-1
// -----------------------------------------------------------------------------
`ifdef GLITCH_SCHED_JITTER_EN
module glitch_lfsr
  import glitch_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  output logic [JITTER_W-1:0] jitter
);

  logic [15:0] lfsr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign jitter = lfsr[JITTER_W-1:0];

endmodule
`endif

// File: rtl/glitch_scheduler.sv
// -----------------------------------------------------------------------------
// glitch_scheduler
// Arms a fault-injection campaign on start, waits for trigger, then after a
// programmable delay emits pulses_cfg pulses of dur_cfg cycles separated by
// gap_cfg cycles on one selected injector channel, either on the random
// (enable) or the specific-value (enable_specific) enable vector.
//
// Optional build macro GLITCH_SCHED_JITTER_EN: adds a 0..7 cycle random offset
// (from glitch_lfsr) to every DELAY and GAP length.
//
// Ports:
//   clk, reset                  : clock (rising edge), async active-high reset
//   start                       : arm a campaign (accepted only in IDLE)
//   abort                       : cancel everything, wins over start/trigger
//   trigger                     : launch the armed sequence
//   target_sel, specific_mode   : channel and vector select (latched on start)
//   delay_cfg, dur_cfg, gap_cfg : cycle counts (latched on start)
//   pulses_cfg                  : pulse count (latched on start, 0 means 1)
//   enable, enable_specific     : registered one-hot injector enables
//   busy                        : registered, high whenever not IDLE
//   done                        : registered one-cycle completion pulse
// -----------------------------------------------------------------------------
module glitch_scheduler
  import glitch_pkg::*;
#(
  parameter int NUM_TARGETS = 4,
  parameter int CNT_W       = 16,
  parameter int REP_W       = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           abort,
  input  logic                           trigger,
  input  logic [$clog2(NUM_TARGETS)-1:0] target_sel,
  input  logic                           specific_mode,
  input  logic [CNT_W-1:0]               delay_cfg,
  input  logic [CNT_W-1:0]               dur_cfg,
  input  logic [CNT_W-1:0]               gap_cfg,
  input  logic [REP_W-1:0]               pulses_cfg,
  output logic [NUM_TARGETS-1:0]         enable,
  output logic [NUM_TARGETS-1:0]         enable_specific,
  output logic                           busy,
  output logic                           done
);

  localparam int TSW = $clog2(NUM_TARGETS);

  // Jitter widens the down-counter by one bit so a maximum length plus the
  // offset can never wrap.
`ifdef GLITCH_SCHED_JITTER_EN
  localparam int CW = CNT_W + 1;
  logic [JITTER_W-1:0] jitter;

  glitch_lfsr u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .jitter (jitter)
  );
`else
  localparam int CW = CNT_W;
`endif

  glitch_state_t          state;
  logic                   launch_pend;
  logic [CW-1:0]          cnt;
  logic [REP_W-1:0]       pulses_left;
  logic [CNT_W-1:0]       delay_lat;
  logic [CNT_W-1:0]       dur_lat;
  logic [CNT_W-1:0]       gap_lat;
  logic [TSW-1:0]         tgt_lat;
  logic                   spec_lat;

  logic [CW-1:0]          eff_delay;
  logic [CW-1:0]          eff_gap;
  logic [CNT_W-1:0]       dur_last;
  logic [NUM_TARGETS-1:0] tgt_onehot;

`ifdef GLITCH_SCHED_JITTER_EN
  assign eff_delay = CW'(delay_lat) + CW'(jitter);
  assign eff_gap   = CW'(gap_lat) + CW'(jitter);
`else
  assign eff_delay = delay_lat;
  assign eff_gap   = gap_lat;
`endif

  // Terminal count for a pulse; a zero duration behaves as one cycle.
  assign dur_last   = (dur_lat == '0) ? '0 : dur_lat - CNT_W'(1);
  assign tgt_onehot = NUM_TARGETS'(1) << tgt_lat;

  // A sampled trigger is first recorded in launch_pend and acted on one edge
  // later. This extra cycle is what places the first pulse at k+1+delay for a
  // zero delay as well, while DELAY itself still lasts exactly delay cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      launch_pend     <= 1'b0;
      cnt             <= '0;
      pulses_left     <= '0;
      delay_lat       <= '0;
      dur_lat         <= '0;
      gap_lat         <= '0;
      tgt_lat         <= '0;
      spec_lat        <= 1'b0;
      enable          <= '0;
      enable_specific <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state           <= IDLE;
        launch_pend     <= 1'b0;
        cnt             <= '0;
        enable          <= '0;
        enable_specific <= '0;
        busy            <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              delay_lat   <= delay_cfg;
              dur_lat     <= dur_cfg;
              gap_lat     <= gap_cfg;
              tgt_lat     <= target_sel;
              spec_lat    <= specific_mode;
              pulses_left <= (pulses_cfg == '0) ? '0 : pulses_cfg - REP_W'(1);
              launch_pend <= 1'b0;
              busy        <= 1'b1;
              state       <= ARMED;
            end
          end

          ARMED: begin
            if (launch_pend) begin
              launch_pend <= 1'b0;
              if (eff_delay != '0) begin
                cnt   <= eff_delay - CW'(1);
                state <= DELAY;
              end else begin
                cnt             <= CW'(dur_last);
                enable          <= spec_lat ? '0 : tgt_onehot;
                enable_specific <= spec_lat ? tgt_onehot : '0;
                state           <= PULSE;
              end
            end else if (trigger) begin
              launch_pend <= 1'b1;
            end
          end

          DELAY: begin
            if (cnt == '0) begin
              cnt             <= CW'(dur_last);
              enable          <= spec_lat ? '0 : tgt_onehot;
              enable_specific <= spec_lat ? tgt_onehot : '0;
              state           <= PULSE;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end

          PULSE: begin
            if (cnt != '0) begin
              cnt <= cnt - CW'(1);
            end else if (pulses_left == '0) begin
              enable          <= '0;
              enable_specific <= '0;
              busy            <= 1'b0;
              done            <= 1'b1;
              state           <= IDLE;
            end else begin
              pulses_left <= pulses_left - REP_W'(1);
              if (eff_gap != '0) begin
                cnt             <= eff_gap - CW'(1);
                enable          <= '0;
                enable_specific <= '0;
                state           <= GAP;
              end else begin
                // Back-to-back pulse: the enable simply stays high.
                cnt <= CW'(dur_last);
              end
            end
          end

          GAP: begin
            if (cnt == '0) begin
              cnt             <= CW'(dur_last);
              enable          <= spec_lat ? '0 : tgt_onehot;
              enable_specific <= spec_lat ? tgt_onehot : '0;
              state           <= PULSE;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end

          default: begin
            enable          <= '0;
            enable_specific <= '0;
            busy            <= 1'b0;
            state           <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_glitch_scheduler.sv
// -----------------------------------------------------------------------------
// tb_glitch_scheduler
// Self-checking bench for glitch_scheduler. Expected waveforms come from a
// pulse-schedule model: with trigger sampled at edge k, pulse i occupies edges
// k+1+delay+i*(dur+gap) .. +dur-1 and done lands one edge after the last pulse.
// -----------------------------------------------------------------------------
module tb_glitch_scheduler;

  localparam int NT = 4;
  localparam int CW = 16;
  localparam int RW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic          trigger;
  logic [1:0]    target_sel;
  logic          specific_mode;
  logic [CW-1:0] delay_cfg;
  logic [CW-1:0] dur_cfg;
  logic [CW-1:0] gap_cfg;
  logic [RW-1:0] pulses_cfg;
  logic [NT-1:0] enable;
  logic [NT-1:0] enable_specific;
  logic          busy;
  logic          done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  glitch_scheduler #(
    .NUM_TARGETS (NT),
    .CNT_W       (CW),
    .REP_W       (RW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .abort           (abort),
    .trigger         (trigger),
    .target_sel      (target_sel),
    .specific_mode   (specific_mode),
    .delay_cfg       (delay_cfg),
    .dur_cfg         (dur_cfg),
    .gap_cfg         (gap_cfg),
    .pulses_cfg      (pulses_cfg),
    .enable          (enable),
    .enable_specific (enable_specific),
    .busy            (busy),
    .done            (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_cfg();
    delay_cfg     = CW'($urandom);
    dur_cfg       = CW'($urandom);
    gap_cfg       = CW'($urandom);
    pulses_cfg    = RW'($urandom);
    target_sel    = 2'($urandom);
    specific_mode = 1'($urandom);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_en"}, enable, 0);
    check({tag, "_es"}, enable_specific, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // One full campaign: start, wait in ARMED, trigger, then compare every edge
  // to the pulse schedule. With noise set, start/trigger/config inputs are
  // randomised while the campaign runs and must have no effect.
  task automatic run_campaign(input int dly, input int dur, input int gap, input int np,
                              input int tgt, input bit spec, input int wait_armed,
                              input bit noise);
    int d, p, per, done_r, rel;
    bit hi;
    logic [NT-1:0] exp_vec;
    delay_cfg     = CW'(dly);
    dur_cfg       = CW'(dur);
    gap_cfg       = CW'(gap);
    pulses_cfg    = RW'(np);
    target_sel    = 2'(tgt);
    specific_mode = spec;
    start         = 1'b1;
    tick();
    start = 1'b0;
    check("arm_busy", busy, 1);
    check("arm_en", enable | enable_specific, 0);
    if (noise) scramble_cfg();
    for (int w = 0; w < wait_armed; w++) begin
      if (noise) start = 1'($urandom);
      tick();
      check("armed_busy", busy, 1);
      check("armed_en", enable | enable_specific, 0);
    end
    start   = 1'b0;
    trigger = 1'b1;
    tick();                               // edge k samples trigger
    trigger = 1'b0;
    d      = (dur == 0) ? 1 : dur;
    p      = (np == 0) ? 1 : np;
    per    = d + gap;
    done_r = 1 + dly + p * d + (p - 1) * gap;
    for (int r = 1; r <= done_r; r++) begin
      if (noise) begin
        start   = 1'($urandom);
        trigger = 1'($urandom);
        scramble_cfg();
      end
      tick();
      rel     = r - 1 - dly;
      hi      = (rel >= 0) && ((rel % per) < d) && ((rel / per) < p);
      exp_vec = hi ? (NT'(1) << tgt) : '0;
      check("seq_en", enable, spec ? '0 : exp_vec);
      check("seq_es", enable_specific, spec ? exp_vec : '0);
      check("seq_busy", busy, (r < done_r) ? 1 : 0);
      check("seq_done", done, (r == done_r) ? 1 : 0);
    end
    start   = 1'b0;
    trigger = 1'b0;
    tick();
    check_idle("post");
  endtask

  initial begin
    reset         = 1'b1;
    start         = 1'b0;
    abort         = 1'b0;
    trigger       = 1'b0;
    target_sel    = '0;
    specific_mode = 1'b0;
    delay_cfg     = '0;
    dur_cfg       = '0;
    gap_cfg       = '0;
    pulses_cfg    = '0;
    #1;
    check_idle("rst_async");
    tick();
    tick();
    check_idle("rst");
    #2 reset = 1'b0;
    tick();
    check_idle("rst_rel");

`ifdef GLITCH_SCHED_JITTER_EN
    begin : jitter_suite
      int seen[int];
      int r;
      for (int c = 0; c < 100; c++) begin
        delay_cfg = 16'd5; dur_cfg = 16'd1; gap_cfg = '0; pulses_cfg = 8'd1;
        target_sel = 2'd0; specific_mode = 1'b0;
        start = 1'b1;
        tick();
        start   = 1'b0;
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        r = 0;
        do begin
          tick();
          r++;
        end while (enable[0] !== 1'b1 && r < 40);
        check("jit_range", ((r - 1) >= 5 && (r - 1) <= 12) ? 1 : 0, 1);
        seen[r - 1] = 1;
        repeat (3) tick();
        check_idle("jit_end");
      end
      check("jit_distinct", (seen.num() > 1) ? 1 : 0, 1);
    end
`else
    // delay=3, dur=2, one pulse, channel 2, random vector.
    run_campaign(3, 2, 0, 1, 2, 1'b0, 0, 1'b0);
    // delay=0, dur=1, gap=2, three pulses, channel 0, specific vector.
    run_campaign(0, 1, 2, 3, 0, 1'b1, 2, 1'b0);
    // dur=0 and pulses=0 collapse to one 1-cycle pulse; busy-time noise ignored.
    run_campaign(2, 0, 5, 0, 3, 1'b0, 1, 1'b1);
    // Back-to-back pulses with gap=0 stay high continuously.
    run_campaign(1, 2, 0, 3, 1, 1'b1, 0, 1'b1);
    // Larger counts.
    run_campaign(1000, 3, 0, 1, 1, 1'b0, 0, 1'b0);
    run_campaign(0, 1, 0, 255, 2, 1'b1, 0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      run_campaign($urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 3),
                   $urandom_range(0, 4), $urandom_range(0, 3), 1'($urandom),
                   $urandom_range(0, 3), 1'b1);
    end

    // Abort during PULSE.
    delay_cfg = '0; dur_cfg = 16'd5; gap_cfg = '0; pulses_cfg = 8'd1;
    target_sel = 2'd1; specific_mode = 1'b0;
    start = 1'b1;
    tick();
    start   = 1'b0;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    tick();
    check("abort_pre_en", enable, 4'b0010);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("abort_pulse");
    tick();
    check_idle("abort_after");

    // Abort together with trigger in ARMED returns to IDLE; later trigger ignored.
    start = 1'b1;
    tick();
    start   = 1'b0;
    abort   = 1'b1;
    trigger = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("abort_trig");
    repeat (4) tick();
    trigger = 1'b0;
    check_idle("abort_trig_late");

    // Abort beats start in IDLE.
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check_idle("abort_start");

    // Reset mid-pulse drops the enable without waiting for an edge.
    delay_cfg = '0; dur_cfg = 16'd3; gap_cfg = 16'd4; pulses_cfg = 8'd3;
    target_sel = 2'd1; specific_mode = 1'b1;
    start = 1'b1;
    tick();
    start   = 1'b0;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    tick();
    check("rst_pre_es", enable_specific, 4'b0010);
    #2 reset = 1'b1;
    #1;
    check_idle("rst_mid_pulse");
    #2 reset = 1'b0;

    // Reset mid-GAP; after release only a new start re-arms.
    start = 1'b1;
    tick();
    start   = 1'b0;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    repeat (5) tick();
    check("gap_pre_busy", busy, 1);
    check("gap_pre_es", enable_specific, 0);
    #2 reset = 1'b1;
    #1;
    check_idle("rst_mid_gap");
    #2 reset = 1'b0;
    trigger = 1'b1;
    repeat (3) tick();
    trigger = 1'b0;
    check_idle("rst_no_rearm");
    run_campaign(1, 1, 1, 2, 3, 1'b0, 0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
